// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache and its ibus/cbus neighbours.
// No logic; types, defaults and enums only.
package icache_direct_pkg;

    localparam int ICACHE_NUM_LINES      = 64;
    localparam int ICACHE_WORDS_PER_LINE = 8;
    localparam int ICACHE_TAG_BITS       = 64 - 3 - $clog2(ICACHE_WORDS_PER_LINE)
                                              - $clog2(ICACHE_NUM_LINES);

    typedef logic [ICACHE_TAG_BITS-1:0] icache_tag_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        mem_size_t   size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_line_ram.sv
// Cache data array: NUM_LINES x WORDS_PER_LINE x 64 flops, asynchronous read.
// One word written per cycle when we_i is high; no backpressure.
module icache_line_ram
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES      = ICACHE_NUM_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
    input  logic                              clk,
    input  logic                              we_i,
    input  logic [$clog2(NUM_LINES)-1:0]      wr_line_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word_i,
    input  logic [63:0]                       wr_data_i,
    input  logic [$clog2(NUM_LINES)-1:0]      rd_line_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word_i,
    output logic [63:0]                       rd_data_o
);

    logic [63:0] mem_q [NUM_LINES][WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_line_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_line_i][rd_word_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped VIVT instruction cache; hits answer in the same cycle, misses take burst+1.
// Fetch is stalled (iresp=0) while a line fill is outstanding; fills follow cresp.ready.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES      = ICACHE_NUM_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  logic       flush,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int WORD_BITS   = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_BITS = 3 + WORD_BITS;
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = 64 - OFFSET_BITS - INDEX_BITS;

    icache_state_t         state_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_arr_q [NUM_LINES];
    logic                  pending_flush_q;
    logic [WORD_BITS-1:0]  cnt_q;
    cbus_req_t             creq_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  miss;
    logic                  fill_we;
    logic                  fill_last;
    logic [63:0]           rd_word;
    logic                  unused_addr_bits;

    assign req_idx  = ireq.addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag  = ireq.addr[63 -: TAG_BITS];
    // The held request address is the line being filled.
    assign fill_idx = creq_q.addr[OFFSET_BITS +: INDEX_BITS];
    assign fill_tag = creq_q.addr[63 -: TAG_BITS];

    assign hit       = (state_q == IDLE) && valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);
    assign miss      = (state_q == IDLE) && ireq.valid && !hit;
    assign fill_we   = (state_q == FETCH) && cresp.ready && reset;
    assign fill_last = fill_we && cresp.last;

    assign unused_addr_bits = ^ireq.addr[1:0];

    icache_line_ram #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_ram (
        .clk       (clk),
        .we_i      (fill_we),
        .wr_line_i (fill_idx),
        .wr_word_i (cnt_q),
        .wr_data_i (cresp.data),
        .rd_line_i (req_idx),
        .rd_word_i (ireq.addr[OFFSET_BITS-1:3]),
        .rd_data_o (rd_word)
    );

    always_comb begin
        iresp = '0;
        if (ireq.valid && hit) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = ireq.addr[2] ? rd_word[63:32] : rd_word[31:0];
        end
    end

    assign creq = creq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            pending_flush_q <= 1'b0;
            cnt_q           <= '0;
            creq_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        state_q <= FETCH;
                        cnt_q   <= '0;
                        creq_q  <= '{valid:    1'b1,
                                     is_write: 1'b0,
                                     size:     MSIZE8,
                                     addr:     {ireq.addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}},
                                     strobe:   '0,
                                     data:     '0,
                                     len:      8'(WORDS_PER_LINE - 1),
                                     burst:    AXI_BURST_INCR};
                    end
                end
                FETCH: begin
                    if (cresp.ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cresp.last) begin
                            state_q <= IDLE;
                            creq_q  <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A flush racing the final beat wins, leaving the new line invalid.
            if (flush) begin
                valid_q <= '0;
            end else if (fill_last) begin
                valid_q[fill_idx] <= !pending_flush_q;
            end

            if (fill_last) begin
                pending_flush_q <= 1'b0;
            end else if (flush && (state_q == FETCH)) begin
                pending_flush_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_last) begin
            tag_arr_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a line-fill memory model and a valid/tag shadow.
module tb_icache_direct;
    import icache_direct_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          NL   = ICACHE_NUM_LINES;
    localparam int          WPL  = ICACHE_WORDS_PER_LINE;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int checks = 0;
    int errors = 0;

    bit          mv [NL];
    logic [51:0] mt [NL];

    always #5 clk = ~clk;

    icache_direct dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .flush (flush),
        .creq  (creq),
        .cresp (cresp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Backing store: low half = word number within region, high half = line byte offset.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return {off[31:0] & 32'hFFFF_FFC0, off[34:3]};
    endfunction

    function automatic logic [31:0] exp_data(input logic [63:0] a);
        logic [63:0] w;
        w = mem_word({a[63:3], 3'b000});
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return mv[a[11:6]] && (mt[a[11:6]] == a[63:12]);
    endfunction

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    // Serves one line burst for address a; returns one negedge after the last beat.
    task automatic serve(input logic [63:0] a, input int flush_beat, input int reset_beat,
                         input int stall_max);
        logic [63:0] la;
        la = {a[63:6], 6'b0};
        for (int i = 0; i < WPL; i++) begin
            repeat ($urandom_range(stall_max)) begin
                @(negedge clk);
                cresp = '0;
                flush = 1'b0;
                #1;
                chk("stall_creq_vld", creq.valid, 1);
                chk("stall_iresp", iresp.data_ok, 0);
            end
            @(negedge clk);
            flush       = (i == flush_beat);
            cresp.ready = 1'b1;
            cresp.last  = (i == WPL - 1);
            cresp.data  = mem_word(la + 64'(8 * i));
            if (i == reset_beat) reset = 1'b0;
            #1;
            chk("creq_vld", creq.valid, 1);
            chk("creq_addr", creq.addr, la);
            chk("iresp_fetch", {iresp.addr_ok, iresp.data_ok, iresp.data}, 0);
            if (i == 0) begin
                chk("creq_len", creq.len, 7);
                chk("creq_burst", creq.burst, AXI_BURST_INCR);
                chk("creq_size", creq.size, MSIZE8);
                chk("creq_write", creq.is_write, 0);
                chk("creq_strobe", creq.strobe, 0);
            end
            if (i == reset_beat) begin
                @(negedge clk);
                cresp = '0;
                #1;
                chk("rst_creq_vld", creq.valid, 0);
                chk("rst_creq_addr", creq.addr, 0);
                chk("rst_iresp", {iresp.addr_ok, iresp.data_ok, iresp.data}, 0);
                reset      = 1'b1;
                ireq.valid = 1'b0;
                flush      = 1'b0;
                model_clear();
                return;
            end
        end
        @(negedge clk);
        cresp = '0;
        flush = 1'b0;
        #1;
        if (flush_beat < 0) begin
            mv[a[11:6]] = 1'b1;
            mt[a[11:6]] = a[63:12];
        end else begin
            model_clear();
        end
    endtask

    task automatic fetch(input logic [63:0] a, input bit exp_miss, input int stall_max);
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        #1;
        if (exp_miss) begin
            chk("miss_dok", iresp.data_ok, 0);
            chk("miss_aok", iresp.addr_ok, 0);
            serve(a, -1, -1, stall_max);
        end
        chk("hit_aok", iresp.addr_ok, 1);
        chk("hit_dok", iresp.data_ok, 1);
        chk("hit_data", iresp.data, exp_data(a));
        chk("hit_no_creq", creq.valid, 0);
        @(negedge clk);
        ireq.valid = 1'b0;
        #1;
        chk("idle_no_creq", creq.valid, 0);
    endtask

    initial begin
        logic [63:0] a;
        ireq  = '0;
        cresp = '0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = BASE;
        #1;
        chk("rst_iresp_dok", iresp.data_ok, 0);
        chk("rst_creq_vld", creq.valid, 0);
        @(negedge clk);
        ireq.valid = 1'b0;
        reset      = 1'b1;

        // 1 cold miss, 2 hit high half of word 3
        fetch(BASE, 1'b1, 0);
        fetch(BASE + 64'h1C, 1'b0, 0);
        fetch(BASE + 64'h14, 1'b0, 0);

        // 3 conflict on same index
        fetch(BASE + 64'(NL * 64), 1'b1, 0);
        fetch(BASE, 1'b1, 0);

        // 4 flush in IDLE: concurrent hit is served, next fetch misses
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = BASE + 64'h8;
        flush      = 1'b1;
        #1;
        chk("flush_hit_dok", iresp.data_ok, 1);
        chk("flush_hit_data", iresp.data, 32'h1);
        @(negedge clk);
        flush      = 1'b0;
        ireq.valid = 1'b0;
        model_clear();
        fetch(BASE, 1'b1, 0);

        // 5 flush at beat 3: full burst consumed, line invalid, refetch
        a = BASE + 64'h240;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        #1;
        chk("t5_miss", iresp.data_ok, 0);
        serve(a, 3, -1, 0);
        chk("t5_line_invalid", iresp.data_ok, 0);
        chk("t5_creq_drop", creq.valid, 0);
        serve(a, -1, -1, 0);
        chk("t5_hit_dok", iresp.data_ok, 1);
        chk("t5_hit_data", iresp.data, 32'h48);
        @(negedge clk);
        ireq.valid = 1'b0;

        // 6 reset at beat 4, then everything misses
        a = BASE + 64'h1088;
        @(negedge clk);
        ireq.valid = 1'b1;
        ireq.addr  = a;
        #1;
        serve(a, -1, 4, 0);
        fetch(BASE + 64'h240, 1'b1, 0);
        fetch(BASE, 1'b1, 0);
        fetch(a, 1'b1, 2);

        // Mixed traffic with stalls against the shadow model
        for (int k = 0; k < 24; k++) begin
            a = BASE + 64'($urandom_range(3) * 4096) + 64'($urandom_range(127) * 4);
            fetch(a, !model_hit(a), 3);
            if (k % 8 == 7) begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
